fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Parametrised successor to the UART buffer FIFO, used for the RX and TX data paths.
- Generic data width and power-of-two depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between uart_rx/uart_tx and the bus-side interface logic.

Parameters:
- D_BIT, 8: data word width in bits.
- ADDR_BIT, 4: address width; depth = 2**ADDR_BIT entries.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL. Legal range 1..2**ADDR_BIT.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Legal range 0..2**ADDR_BIT-1.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- clr, in, 1: synchronous flush. Same effect as rst on pointers, count and flags; storage contents untouched.
- wr, in, 1: write request; pushes w_data this cycle.
- rd, in, 1: read request; pops the head entry this cycle.
- w_data, in, D_BIT: write data.
- r_data, out, D_BIT: head entry (show-ahead). Valid whenever empty=0.
- full, out, 1: count == 2**ADDR_BIT.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- count, out, ADDR_BIT+1: current number of stored entries.
- overflow, out, 1: sticky; set by a write that is rejected.
- underflow, out, 1: sticky; set by a read that is rejected.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Reset takes priority over clr, wr and rd. Storage array is not reset; r_data is don't-care while empty=1.
- clr=1 (rst=0): identical to reset except storage. clr takes priority over wr/rd in the same cycle; no error flags are set that cycle.
- Read data path:
  - r_data = mem[rd_ptr], combinational from storage (zero-latency show-ahead).
  - A pop advances rd_ptr at the edge; the next entry appears on r_data in the following cycle.
- Write is accepted when wr=1 and (full=0 or a read is accepted the same cycle): mem[wr_ptr] <= w_data, wr_ptr increments.
- Read is accepted when rd=1 and empty=0: rd_ptr increments.
- Simultaneous events:
  - wr & rd, neither full nor empty: both accepted, count unchanged.
  - wr & rd while full: both accepted (head popped, new word stored), count stays at depth, full stays 1, no overflow.
  - wr & rd while empty: write accepted, read rejected, underflow set; next cycle count=1, empty=0.
  - wr while full with no rd: write dropped, storage and pointers unchanged, overflow <= 1.
  - rd while empty: no pointer change, underflow <= 1.
- Pointers are ADDR_BIT wide and wrap naturally from 2**ADDR_BIT-1 to 0.
- count is an up/down counter (+1 on write only, -1 on read only).
- All flags are registered, computed from the next count value, so they are valid in the same cycle count updates. No combinational path from wr/rd to any flag.
- Latency:
  - A word written at edge N appears on r_data after edge N when the FIFO was empty.
  - empty deasserts after edge N.
- overflow/underflow stay set until rst or clr.

Decomposition:
- Shared header fifo_defs.vh holds:
  - default width/depth constants (FIFO_D_BIT=8, FIFO_ADDR_BIT=4);
  - a function/macro for threshold range checking (elaboration-time error on illegal AF_LEVEL/AE_LEVEL).
- One sub-module: fifo_flex_ctrl.
  - Owns pointers, count, accept logic and all flag registers.
  - Outputs w_addr, r_addr and wr_en to the existing parametrised register_file, which holds storage.

Test Plan:
- Reset/idle: assert rst 2 cycles -> empty=1, almost_empty=1, full=0, count=0, overflow=0, underflow=0.
- Fill/drain (D_BIT=8, ADDR_BIT=4): write 0x00..0x0F on consecutive cycles, then read 16 times.
  - almost_full rises when count=14; full=1 after the 16th write.
  - r_data sequence 0x00..0x0F; empty=1 after the last read.
- Overflow and full bypass:
  - At full, wr=1 with w_data=0xAA -> overflow=1, count=16, head unchanged.
  - Then wr&rd with 0xBB -> count=16, 0xBB read out last.
- Underflow and empty bypass:
  - While empty, rd=1 -> underflow=1, count=0.
  - wr&rd with 0x5A while empty -> count=1, r_data=0x5A next cycle, underflow=1.
- Wrap-around: 40 cycles of random wr/rd with a scoreboard -> data order preserved across pointer wrap; count matches the model every cycle.
- Flush mid-operation:
  - count=9, pulse clr together with wr=1 -> count=0, empty=1, sticky flags cleared, written word discarded.
  - Subsequent write 0x33 -> r_data=0x33.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : fifo_flex_pkg                                                  |
// | Purpose   : Shared defaults, flag bundle type and threshold range checks   |
// |             for the fifo_flex buffer and its controller.                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package fifo_flex_pkg;

  localparam int FIFO_D_BIT    = 8;
  localparam int FIFO_ADDR_BIT = 4;

  // All status flags travel together so reset/flush can load them in one go.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  // almost_full must be reachable and non-trivial: 1..depth.
  function automatic bit af_level_ok(input int af, input int addr_bit);
    return (af >= 1) && (af <= (1 << addr_bit));
  endfunction

  // almost_empty must be able to deassert: 0..depth-1.
  function automatic bit ae_level_ok(input int ae, input int addr_bit);
    return (ae >= 0) && (ae <= (1 << addr_bit) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_flex_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fifo_flex_ctrl                                                 |
// | Purpose   : Pointer, occupancy and flag control for fifo_flex.             |
// | Ports     : clk, rst, clr, wr, rd in; w_addr, r_addr, wr_en to storage;     |
// |             count and registered flag bundle out.                          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fifo_flex_ctrl
  import fifo_flex_pkg::*;
#(
  parameter int ADDR_BIT = FIFO_ADDR_BIT,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr,
  input  logic                rd,
  output logic [ADDR_BIT-1:0] w_addr,
  output logic [ADDR_BIT-1:0] r_addr,
  output logic                wr_en,
  output logic [ADDR_BIT:0]   count,
  output fifo_flags_t         flags
);

  localparam logic [ADDR_BIT:0]   c_depth   = (ADDR_BIT+1)'(1 << ADDR_BIT);
  localparam logic [ADDR_BIT:0]   c_af      = (ADDR_BIT+1)'(AF_LEVEL);
  localparam logic [ADDR_BIT:0]   c_ae      = (ADDR_BIT+1)'(AE_LEVEL);
  localparam logic [ADDR_BIT:0]   c_cnt_one = (ADDR_BIT+1)'(1);
  localparam logic [ADDR_BIT-1:0] c_ptr_one = ADDR_BIT'(1);
  localparam fifo_flags_t         c_flags_rst = '{
    full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
    overflow: 1'b0, underflow: 1'b0
  };

  logic [ADDR_BIT-1:0] r_wr_ptr;
  logic [ADDR_BIT-1:0] r_rd_ptr;
  logic [ADDR_BIT:0]   r_count;
  fifo_flags_t         r_flags;

  logic                w_rd_ok;
  logic                w_wr_ok;
  logic [ADDR_BIT:0]   w_count_nxt;

  // A read frees the head slot in the same edge, so a full FIFO can still
  // accept a write when it is also being read.
  always_comb begin
    w_rd_ok     = rd & ~r_flags.empty;
    w_wr_ok     = wr & (~r_flags.full | w_rd_ok);
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (w_rd_ok && !w_wr_ok) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  // Flush discards the concurrent write without touching storage.
  assign wr_en  = w_wr_ok & ~clr & ~rst;
  assign w_addr = r_wr_ptr;
  assign r_addr = r_rd_ptr;
  assign count  = r_count;
  assign flags  = r_flags;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_flags  <= c_flags_rst;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count              <= w_count_nxt;
      // Level flags are derived from the next count so they line up with it.
      r_flags.full         <= (w_count_nxt == c_depth);
      r_flags.empty        <= (w_count_nxt == '0);
      r_flags.almost_full  <= (w_count_nxt >= c_af);
      r_flags.almost_empty <= (w_count_nxt <= c_ae);
      r_flags.overflow     <= r_flags.overflow  | (wr & ~w_wr_ok);
      r_flags.underflow    <= r_flags.underflow | (rd & ~w_rd_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : register_file                                                  |
// | Purpose   : Parametrised storage array, synchronous write, combinational   |
// |             read. Contents are not reset.                                  |
// | Ports     : clk, wr_en, w_addr, r_addr, w_data -> r_data = mem[r_addr]      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[w_addr] <= w_data;
    end
  end

  assign r_data = r_mem[r_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_flex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fifo_flex                                                      |
// | Purpose   : Show-ahead FIFO with occupancy count, programmable almost      |
// |             flags, sticky overflow/underflow and synchronous flush.        |
// | Ports     : clk, rst, clr, wr, rd, w_data in; r_data, full, empty,         |
// |             almost_full, almost_empty, count, overflow, underflow out.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int D_BIT    = FIFO_D_BIT,
  parameter int ADDR_BIT = FIFO_ADDR_BIT,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr,
  input  logic                rd,
  input  logic [D_BIT-1:0]    w_data,
  output logic [D_BIT-1:0]    r_data,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_BIT:0]   count,
  output logic                overflow,
  output logic                underflow
);

  if (!af_level_ok(AF_LEVEL, ADDR_BIT)) begin : g_bad_af_level
    $error("fifo_flex: AF_LEVEL out of range 1..2**ADDR_BIT");
  end
  if (!ae_level_ok(AE_LEVEL, ADDR_BIT)) begin : g_bad_ae_level
    $error("fifo_flex: AE_LEVEL out of range 0..2**ADDR_BIT-1");
  end

  logic [ADDR_BIT-1:0] w_w_addr;
  logic [ADDR_BIT-1:0] w_r_addr;
  logic                w_wr_en;
  fifo_flags_t         w_flags;

  fifo_flex_ctrl #(
    .ADDR_BIT (ADDR_BIT),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wr     (wr),
    .rd     (rd),
    .w_addr (w_w_addr),
    .r_addr (w_r_addr),
    .wr_en  (w_wr_en),
    .count  (count),
    .flags  (w_flags)
  );

  register_file #(
    .DATA_W (D_BIT),
    .ADDR_W (ADDR_BIT)
  ) u_mem (
    .clk    (clk),
    .wr_en  (w_wr_en),
    .w_addr (w_w_addr),
    .r_addr (w_r_addr),
    .w_data (w_data),
    .r_data (r_data)
  );

  assign full         = w_flags.full;
  assign empty        = w_flags.empty;
  assign almost_full  = w_flags.almost_full;
  assign almost_empty = w_flags.almost_empty;
  assign overflow     = w_flags.overflow;
  assign underflow    = w_flags.underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_fifo_flex                                                   |
// | Purpose   : Self-checking bench for fifo_flex with a queue scoreboard.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       pop_valid;
  logic [7:0] exp_pop;
  logic [7:0] obs_pop;

  always #5 clk = ~clk;

  fifo_flex dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr           (wr),
    .rd           (rd),
    .w_data       (w_data),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // One clock of stimulus; updates the reference queue and captures the head
  // word the DUT shows while a pop is being accepted.
  task automatic step(input logic a_wr, input logic a_rd, input logic [7:0] a_d,
                      input logic a_clr);
    bit rd_ok, wr_ok;
    wr = a_wr; rd = a_rd; w_data = a_d; clr = a_clr;
    pop_valid = 1'b0;
    if (a_clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = a_rd && (q.size() > 0);
      wr_ok = a_wr && ((q.size() < 16) || rd_ok);
      if (rd_ok) begin
        pop_valid = 1'b1;
        exp_pop   = q.pop_front();
        obs_pop   = r_data;
      end
      if (wr_ok) q.push_back(a_d);
      if (a_wr && !wr_ok) m_ovf = 1'b1;
      if (a_rd && !rd_ok) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", almost_full); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", underflow); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      n_checks++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_checks++; if (almost_full !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 14)); end
      n_checks++; if (almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i + 1 <= 2)); end
      n_checks++; if (full !== (i == 15)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 15)); end
      n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (!pop_valid || obs_pop !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, obs_pop, 8'(i)); end
      n_checks++; if (count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 15 - i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_unf: got %b want 0", underflow); end
  endtask

  task automatic test_overflow_bypass();
    logic [7:0] last;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
    n_checks++; if (r_data !== q[0]) begin n_fail++; $display("FAIL ovf_head: got %h want %h", r_data, q[0]); end
    step(1'b1, 1'b1, 8'hBB, 1'b0);
    n_checks++; if (!pop_valid || obs_pop !== exp_pop) begin n_fail++; $display("FAIL byp_full_pop: got %h want %h", obs_pop, exp_pop); end
    n_checks++; if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL byp_full_count: got %0d/%b want 16/1", count, full); end
    n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL byp_full_ovf: got %b want %b", overflow, m_ovf); end
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (!pop_valid || obs_pop !== exp_pop) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, obs_pop, exp_pop); end
      last = obs_pop;
    end
    n_checks++; if (last !== 8'hBB) begin n_fail++; $display("FAIL ovf_last: got %h want bb", last); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_underflow_bypass();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b want 1", underflow); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL unf_count: got %0d want 0", count); end
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    n_checks++; if (count !== 5'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL byp_empty_count: got %0d/%b want 1/0", count, empty); end
    n_checks++; if (r_data !== 8'h5A) begin n_fail++; $display("FAIL byp_empty_data: got %h want 5a", r_data); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL byp_empty_unf: got %b want 1", underflow); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (!pop_valid || obs_pop !== 8'h5A) begin n_fail++; $display("FAIL byp_empty_pop: got %h want 5a", obs_pop); end
  endtask

  task automatic test_wrap();
    logic a_wr, a_rd;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      a_wr = ($urandom_range(3) != 0);
      a_rd = ($urandom_range(1) != 0);
      step(a_wr, a_rd, 8'($urandom), 1'b0);
      if (pop_valid) begin
        n_checks++; if (obs_pop !== exp_pop) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, obs_pop, exp_pop); end
      end
      n_checks++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, q.size()); end
      n_checks++; if (empty !== (q.size() == 0) || full !== (q.size() == 16)) begin n_fail++; $display("FAIL wrap_levels[%0d]: got e%b f%b want e%b f%b", i, empty, full, (q.size() == 0), (q.size() == 16)); end
      n_checks++; if (overflow !== m_ovf || underflow !== m_unf) begin n_fail++; $display("FAIL wrap_sticky[%0d]: got o%b u%b want o%b u%b", i, overflow, underflow, m_ovf, m_unf); end
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    n_checks++; if (count !== 5'd9 || underflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0d/%b want 9/1", count, underflow); end
    step(1'b1, 1'b0, 8'h77, 1'b1);
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d/%b want 0/1", count, empty); end
    n_checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_sticky: got o%b u%b want 0 0", overflow, underflow); end
    n_checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_almost: got ae%b af%b want 1 0", almost_empty, almost_full); end
    step(1'b1, 1'b0, 8'h33, 1'b0);
    n_checks++; if (r_data !== 8'h33 || count !== 5'd1) begin n_fail++; $display("FAIL flush_after: got %h/%0d want 33/1", r_data, count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_bypass();
    test_underflow_bypass();
    test_wrap();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
